// File: rtl/z_seq_mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encodings and the
// step-counter width helper.
package z_seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest width that can count from 0 up to n without wrapping.
  function automatic int cnt_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(n + 1)) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/z_n_rca.sv
// n-bit ripple-carry adder; the only arithmetic element of the multiplier.
module z_n_rca #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         c_in,
  output logic [n-1:0] sum,
  output logic         c_out
);

  logic [n:0] carry;

  assign carry[0] = c_in;

  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_bit
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = carry[n];

endmodule

// File: rtl/z_seq_mult.sv
// Sequential shift-add unsigned multiplier: one add/shift step per clock,
// n steps per product, with a one-cycle done pulse.
module z_seq_mult
  import z_seq_mult_pkg::*;
#(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] product
);

  localparam int CW = cnt_width(n);
  localparam logic [CW-1:0] LAST_STEP = CW'(n - 1);

  state_t        state_reg;
  logic [n-1:0]  mcand_reg;
  logic [n-1:0]  mq_reg;
  logic [n-1:0]  acc_reg;
  logic [CW-1:0] step_reg;
  logic          carry_reg;

  logic [n-1:0]  addend;
  logic [n-1:0]  sum;
  logic          c_out;

  // Gating the addend with mq[0] turns the adder into a pass-through of acc.
  assign addend = mq_reg[0] ? mcand_reg : '0;

  z_n_rca #(.n(n)) u_rca (
    .a     (acc_reg),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      mq_reg    <= '0;
      acc_reg   <= '0;
      step_reg  <= '0;
      carry_reg <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand_reg <= a;
            mq_reg    <= b;
            acc_reg   <= '0;
            step_reg  <= '0;
            carry_reg <= 1'b0;
            busy      <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          // Carry-out becomes the new top bit of acc, so nothing overflows.
          acc_reg   <= {c_out, sum[n-1:1]};
          mq_reg    <= {sum[0], mq_reg[n-1:1]};
          carry_reg <= c_out;
          step_reg  <= step_reg + CW'(1);
          if (step_reg == LAST_STEP) begin
            product   <= {c_out, sum, mq_reg[n-1:1]};
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          carry_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z_seq_mult.sv
// Self-checking bench for z_seq_mult at n=4 and n=8 against a plain a*b model.
module tb_z_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int errors = 0;
  int checks = 0;
  logic prev_done4 = 1'b0;
  logic prev_done8 = 1'b0;

  always #5 clk = ~clk;

  z_seq_mult #(.n(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  z_seq_mult #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      start4 = s; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = s; a8 = a; b8 = b;
    end
  endtask

  function automatic logic busy_of(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic [15:0] prod_of(input int w);
    return (w == 4) ? {8'd0, prod4} : prod8;
  endfunction

  // done must never be high on two consecutive cycles
  always @(negedge clk) begin
    if (done4) check("done4_pulse", {63'd0, prev_done4}, 64'd0);
    if (done8) check("done8_pulse", {63'd0, prev_done8}, 64'd0);
    prev_done4 <= done4;
    prev_done8 <= done8;
  end

  // Issue one operation from a negedge and wait for its done pulse.
  // hold: keep start high and swap operands to 7/7 while the operation runs.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input string tag, input bit hold);
    int lat;
    bit seen;
    int unsigned expected;
    expected = int'(a) * int'(b);
    @(negedge clk);
    drive(w, 1'b1, a, b);
    @(posedge clk);
    lat = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (hold) drive(w, 1'b1, 8'd7, 8'd7);
      else      drive(w, 1'b0, a, b);
      if (lat <= w + 1) check({tag, "_busy"}, {63'd0, busy_of(w)}, 64'd1);
      if (done_of(w)) seen = 1;
    end
    check({tag, "_lat"}, lat, w + 1);
    check({tag, "_prod"}, {48'd0, prod_of(w)}, {32'd0, expected});
    $display("op n=%0d %s a=%0d b=%0d product=%0d latency=%0d", w, tag, a, b, prod_of(w), lat);
  endtask

  initial begin
    int ndone;
    logic [7:0] ra, rb;
    rst = 1'b1;
    drive(4, 1'b0, 8'd0, 8'd0);
    drive(8, 1'b0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy4", {63'd0, busy4}, 64'd0);
    check("rst_done4", {63'd0, done4}, 64'd0);
    check("rst_prod4", {56'd0, prod4}, 64'd0);
    check("rst_prod8", {48'd0, prod8}, 64'd0);
    rst = 1'b0;

    run_op(4, 8'd3, 8'd5, "basic", 0);
    @(negedge clk);
    check("basic_idle_busy", {63'd0, busy4}, 64'd0);
    check("basic_idle_done", {63'd0, done4}, 64'd0);
    check("basic_hold_prod", {56'd0, prod4}, 64'd15);

    run_op(4, 8'd15, 8'd15, "c15x15", 0);
    run_op(4, 8'd0,  8'd13, "c0x13", 0);
    run_op(4, 8'd15, 8'd1,  "c15x1", 0);
    run_op(4, 8'd1,  8'd0,  "c1x0", 0);

    // start held high with operands changed mid-operation
    run_op(4, 8'd6, 8'd11, "ign", 1);
    @(negedge clk);
    check("ign_idle_busy", {63'd0, busy4}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 20 && ndone == 0; i++) begin
      @(negedge clk);
      if (done4) ndone = i + 1;
    end
    drive(4, 1'b0, 8'd0, 8'd0);
    check("ign_second_lat", ndone, 5);
    check("ign_second_prod", {56'd0, prod4}, 64'd49);
    $display("op n=4 ign_second product=%0d latency=%0d", prod4, ndone);

    // reset during step 2 of 9*9
    @(negedge clk);
    drive(4, 1'b1, 8'd9, 8'd9);
    @(posedge clk);
    @(negedge clk);
    drive(4, 1'b0, 8'd9, 8'd9);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'd0, busy4}, 64'd0);
    check("abort_done", {63'd0, done4}, 64'd0);
    check("abort_prod", {56'd0, prod4}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("abort_no_done", ndone, 0);
    $display("op n=4 abort a=9 b=9 done_pulses=%0d", ndone);

    run_op(4, 8'd2, 8'd7, "post_rst", 0);
    run_op(8, 8'd255, 8'd255, "w255x255", 0);
    run_op(8, 8'd200, 8'd3,   "w200x3", 0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      run_op(4, ra, rb, "rnd4", 0);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(8, ra, rb, "rnd8", 0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/z_seq_mult.md
Z_SEQ_MULT -- requirements
Module: z_seq_mult

Interface
REQ-001 Parameter: n, default 4, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 Port: a  input  n  multiplicand, unsigned; captured on the accepting edge only.
REQ-006 Port: b  input  n  multiplier, unsigned; captured on the accepting edge only.
REQ-007 Port: busy  output  1  high while state is CALC or DONE.
REQ-008 Port: done  output  1  one-cycle pulse; product valid while high.
REQ-009 Port: product  output  2n  unsigned a*b; holds its value until the next accepted start.

Function
REQ-010 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-011 IDLE -> CALC on a rising edge with start=1.
  - On that edge: mcand<=a, mq<=b, acc<=0, carry<=0, step<=0.
REQ-012 CALC SHALL perform one shift-add step per clock.
  - Sum term: if mq[0]=1, {c,s}=acc+mcand through the n-bit ripple adder with c_in=0; otherwise {c,s}={0,acc}.
  - Shift: {acc,mq}<={c,s,mq[n-1:1]}.
  - Counter: step<=step+1.
REQ-013 CALC -> DONE on the edge that completes step n; exactly n steps are executed.
REQ-014 DONE -> IDLE unconditionally after one cycle.
REQ-015 done SHALL be 1 only in DONE, and product SHALL equal {acc,mq} in DONE.
REQ-016 Latency: done is high in the cycle following the n-th edge after the accepting edge; the next start is accepted no earlier than the IDLE cycle after DONE.
REQ-017 start in CALC or DONE SHALL be ignored, with no queuing and no effect on operands.
REQ-018 Changes on a or b after acceptance SHALL NOT affect the result.
REQ-019 product SHALL NOT overflow: the maximum (2^n-1)^2 fits in 2n bits; the adder carry-out SHALL be kept as the top bit of each step.
REQ-020 The step counter SHALL be ceil(log2(n+1)) bits wide and SHALL NOT wrap during an operation.
REQ-021 The ripple adder SHALL be the only arithmetic element; no '*' operator SHALL be used.

Reset
REQ-022 With rst=1 at a clock edge, the block SHALL enter IDLE with acc, mq, mcand, carry, step and product all 0.
REQ-023 After reset: busy=0, done=0, product=0.
REQ-024 rst SHALL take priority over start.
REQ-025 rst during CALC or DONE SHALL abort the operation with no done pulse.
REQ-026 The first start after reset is deassertion SHALL be accepted normally.

Structure
REQ-027 A shared package/include file SHALL hold the state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the counter-width constant function.
REQ-028 One sub-module SHALL be used: z_n_rca instantiated with n=n, ports sum, c_out, a=acc, b=mcand gated by mq[0], c_in=0.
REQ-029 The FSM, counter and shift registers SHALL live in z_seq_mult; the target size is 150-250 lines of RTL.

Verification
REQ-030 Basic multiply, n=4: a=3, b=5, start for 1 cycle -> busy=1 for 5 cycles; done=1 exactly 5 cycles after the accepting edge; product=15.
REQ-031 Corner values, n=4:
  - a=15, b=15 -> product=225.
  - a=0, b=13 -> product=0.
  - a=15, b=1 -> product=15.
  - a=1, b=0 -> product=0.
REQ-032 Ignored start: start held high, with a and b changed mid-CALC to 7/7 -> first result equals the originally captured operands; the second operation starts only after DONE->IDLE.
REQ-033 Mid-operation reset: rst=1 at step 2 of a=9, b=9 -> next cycle busy=0, done=0, product=0; no done pulse appears later.
REQ-034 Wide instance, n=8: a=255, b=255 -> product=65025 after 8 steps; a=200, b=3 -> product=600.
REQ-035 Randomized check: 1000 back-to-back random operations at n=4 and n=8, compared against a reference a*b -> zero mismatches; done is never high for two consecutive cycles.
